// File: rtl/sel_decoder_seq_pkg.sv
// Shared definitions for the registered select decoder.
//   - MODE_* : command encodings carried on the mode field
//   - state_t: controller states (IDLE / HOLD / SCAN)
package cpu_pkg;

  localparam logic [1:0] MODE_DECODE = 2'd0;
  localparam logic [1:0] MODE_THERMO = 2'd1;
  localparam logic [1:0] MODE_SCAN   = 2'd2;
  localparam logic [1:0] MODE_CLEAR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

endpackage

// File: rtl/sel_decoder_seq_if.sv
// Command/strobe bundle for sel_decoder_seq.
//   master (requester): drives in_valid, mode, sel, last, abort;
//                       observes in_ready, out, busy, done
//   slave  (decoder)  : the mirror image
//
// Handshake: a command transfers on a rising clock edge where
// in_valid && in_ready are both 1. mode/sel/last are sampled only on that
// edge. in_valid may be raised at any time and does not depend on in_ready.
// abort is a synchronous cancel that overrides any transfer on its edge.
interface sel_decoder_seq_if #(
  parameter int SEL_WIDTH = 4
);
  localparam int NOUT = 1 << SEL_WIDTH;

  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           mode;
  logic [SEL_WIDTH-1:0] sel;
  logic [SEL_WIDTH-1:0] last;
  logic                 abort;
  logic [NOUT-1:0]      out;
  logic                 busy;
  logic                 done;

  modport master (
    output in_valid, mode, sel, last, abort,
    input  in_ready, out, busy, done
  );

  modport slave (
    input  in_valid, mode, sel, last, abort,
    output in_ready, out, busy, done
  );
endinterface

// File: rtl/sel_decoder_seq_pattern_gen.sv
// sel_pattern_gen: combinational (mode, index) -> strobe pattern.
//   mode    : MODE_THERMO gives bits [index:0] set, anything else one-hot
//   index   : line number
//   pattern : NOUT-bit result (registered by the parent)
module sel_pattern_gen
  import cpu_pkg::*;
#(
  parameter int SEL_WIDTH = 4,
  localparam int NOUT = 1 << SEL_WIDTH
) (
  input  logic [1:0]           mode,
  input  logic [SEL_WIDTH-1:0] index,
  output logic [NOUT-1:0]      pattern
);

  always_comb begin
    pattern = '0;
    for (int i = 0; i < NOUT; i++) begin
      if (mode == MODE_THERMO) pattern[i] = (i <= int'(index));
      else                     pattern[i] = (i == int'(index));
    end
  end

endmodule

// File: rtl/sel_decoder_seq.sv
// sel_decoder_seq: registered SEL_WIDTH -> 2**SEL_WIDTH strobe decoder with
// a valid/ready command port. Patterns: timed one-hot, timed thermometer,
// and an auto-stepping one-hot scan from sel to last (wrapping).
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   bus       : sel_decoder_seq_if slave (command in, strobes/status out)
//   dbg_state : current controller state, for observation only
// out is driven straight from a register, so sel never reaches it
// combinationally.
module sel_decoder_seq
  import cpu_pkg::*;
#(
  parameter int SEL_WIDTH   = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  sel_decoder_seq_if.slave    bus,
  output state_t              dbg_state
);
  localparam int NOUT = 1 << SEL_WIDTH;
  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [SEL_WIDTH-1:0] pos_q, pos_d;
  logic [SEL_WIDTH-1:0] last_q, last_d;
  logic [NOUT-1:0]      out_q, out_d;
  logic                 done_q, done_d;

  logic [1:0]           gen_mode;
  logic [SEL_WIDTH-1:0] gen_idx;
  logic [NOUT-1:0]      gen_pat;
  logic [SEL_WIDTH-1:0] pos_inc;

  // Natural overflow of the SEL_WIDTH-bit position is the modulo-NOUT wrap.
  assign pos_inc = pos_q + 1'b1;

  sel_pattern_gen #(.SEL_WIDTH(SEL_WIDTH)) u_pattern_gen (
    .mode    (gen_mode),
    .index   (gen_idx),
    .pattern (gen_pat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pos_q   <= '0;
      last_q  <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      last_q  <= last_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    last_d   = last_q;
    out_d    = out_q;
    done_d   = 1'b0;
    gen_mode = MODE_DECODE;
    gen_idx  = bus.sel;

    if (bus.abort) begin
      // Beats completion and any pending accept on this edge.
      state_d = IDLE;
      out_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            case (bus.mode)
              MODE_DECODE, MODE_THERMO: begin
                gen_mode = bus.mode;
                out_d    = gen_pat;
                cnt_d    = HOLD_RELOAD;
                state_d  = HOLD;
              end
              MODE_SCAN: begin
                out_d   = gen_pat;
                pos_d   = bus.sel;
                last_d  = bus.last;
                cnt_d   = HOLD_RELOAD;
                state_d = SCAN;
              end
              default: begin
                out_d  = '0;
                done_d = 1'b1;
              end
            endcase
          end
        end
        HOLD: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            out_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        SCAN: begin
          gen_idx = pos_inc;
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else if (pos_q != last_q) begin
            pos_d = pos_inc;
            out_d = gen_pat;
            cnt_d = HOLD_RELOAD;
          end else begin
            out_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          out_d   = '0;
        end
      endcase
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.out      = out_q;
  assign bus.done     = done_q;
  assign dbg_state    = state_q;

endmodule
